// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// FSM states and the default iteration count.
package muldiv_pkg;

  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } md_state_t;

  function automatic logic md_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle on magnitudes; signs applied in FIXUP.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_t          r_state;
  md_state_t          w_state_next;
  md_op_t             r_op;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_count;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div0;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_mt_ok;
  logic               w_in_signed;
  logic               w_in_div;
  logic               w_in_div0;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  // Operand conditioning at launch. A zero divisor keeps the raw dividend so the
  // remainder comes out as srca unchanged and the quotient as all ones.
  always_comb begin
    w_in_signed = md_is_signed(op);
    w_in_div    = md_is_div(op);
    w_in_div0   = w_in_div && (srcb == '0);
    w_abs_a     = (w_in_signed && srca[WIDTH-1] && !w_in_div0) ? -srca : srca;
    w_abs_b     = (w_in_signed && srcb[WIDTH-1]) ? -srcb : srcb;
  end

  // Multiply: {carry,upper} += multiplicand when multiplier LSB set, then shift right.
  // Divide: shift remainder left, keep the trial subtraction when it does not borrow.
  always_comb begin
    w_add   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
    if (!md_is_div(r_op)) begin
      w_step = {w_add, r_acc[WIDTH-1:1]};
    end else if (w_trial[WIDTH]) begin
      w_step = {r_acc[2*WIDTH-2:0], 1'b0};
    end else begin
      w_step = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    w_prod_fix = r_neg_q ? -r_acc : r_acc;
    if (!md_is_div(r_op)) begin
      w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod_fix[WIDTH-1:0];
    end else if (r_div0) begin
      w_fix_hi = r_acc[2*WIDTH-1:WIDTH];
      w_fix_lo = r_acc[WIDTH-1:0];
    end else begin
      w_fix_hi = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      w_fix_lo = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_mt_ok      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = start;
        w_mt_ok  = !start;
        if (start) w_state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (r_count == CW'(WIDTH - 1)) w_state_next = FIXUP;
      end
      FIXUP: begin
        busy         = 1'b1;
        w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_accept     = start;
        w_mt_ok      = !start;
        w_state_next = start ? CALC : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_op    <= MD_MULT;
      r_b     <= '0;
      r_acc   <= '0;
      r_count <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op    <= op;
        r_b     <= w_in_div ? w_abs_b : w_abs_a;
        r_acc   <= {{WIDTH{1'b0}}, (w_in_div ? w_abs_a : w_abs_b)};
        r_count <= '0;
        r_neg_q <= w_in_signed && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
        r_neg_r <= w_in_signed && srca[WIDTH-1];
        r_div0  <= w_in_div0;
      end else if (r_state == CALC) begin
        r_acc   <= w_step;
        r_count <= r_count + 1'b1;
      end
      // HI/LO only change on result write-back or an uncontested mthi/mtlo.
      if (r_state == FIXUP) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end else if (w_mt_ok) begin
        if (mthi) r_hi <= wdata;
        if (mtlo) r_lo <= wdata;
      end
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, signed/unsigned arithmetic,
// special divide cases, mthi/mtlo arbitration and mid-operation reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  md_op_t       op;
  logic [W-1:0] srca;
  logic [W-1:0] srcb;
  logic         mthi;
  logic         mtlo;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .srca  (srca),
    .srcb  (srcb),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Pulse start for one edge; operands are scrambled afterwards to prove capture.
  task automatic launch(input md_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit sync_neg);
    if (sync_neg) @(negedge clk);
    op    = o;
    srca  = a;
    srcb  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    srca  = 32'hA5A5_A5A5;
    srcb  = 32'h5A5A_5A5A;
  endtask

  // Called at the negedge after the start edge; returns edges until done (-1 on timeout).
  task automatic wait_done(output int edges, output int busy_cycles);
    edges       = -1;
    busy_cycles = busy ? 1 : 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin
        edges = k;
        break;
      end
      if (busy) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = MD_MULTU; srca = '0; srcb = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (hi !== 32'h0) begin n_errors++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
    n_checks++; if (lo !== 32'h0) begin n_errors++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
    reset = 1'b0;
    $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
  endtask

  task automatic test_multu();
    int e, b;
    launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done(e, b);
    n_checks++; if (e !== 33) begin n_errors++; $display("FAIL multu_latency: got %0d edges expected 33", e); end
    n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
    n_checks++; if (lo !== 32'h0000_0001) begin n_errors++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
    $display("MULTU ffffffff*ffffffff: hi=%h lo=%h edges=%0d", hi, lo, e);
  endtask

  task automatic test_mult();
    int e, b;
    launch(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
    wait_done(e, b);
    n_checks++; if (b !== 33) begin n_errors++; $display("FAIL mult_busy_cycles: got %0d expected 33", b); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFEB) begin n_errors++; $display("FAIL mult_lo: got %h expected ffffffeb", lo); end
    $display("MULT -3*7: hi=%h lo=%h busy_cycles=%0d", hi, lo, b);
  endtask

  task automatic test_back_to_back();
    int e, b;
    launch(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(e, b);
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_errors++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
    $display("DIV -7/2: hi=%h lo=%h", hi, lo);
    launch(MD_DIVU, 32'd100, 32'd7, 1'b0);
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_errors++; $display("FAIL calc_lo_hold: got %h expected fffffffd", lo); end
    wait_done(e, b);
    n_checks++; if (e !== 33) begin n_errors++; $display("FAIL b2b_latency: got %0d edges expected 33", e); end
    n_checks++; if (lo !== 32'd14) begin n_errors++; $display("FAIL divu_lo: got %h expected 0000000e", lo); end
    n_checks++; if (hi !== 32'd2) begin n_errors++; $display("FAIL divu_hi: got %h expected 00000002", hi); end
    $display("DIVU 100/7 back-to-back: hi=%h lo=%h edges=%0d", hi, lo, e);
  endtask

  task automatic test_div_special();
    int e, b;
    launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(e, b);
    n_checks++; if (lo !== 32'h8000_0000) begin n_errors++; $display("FAIL ovf_lo: got %h expected 80000000", lo); end
    n_checks++; if (hi !== 32'h0) begin n_errors++; $display("FAIL ovf_hi: got %h expected 00000000", hi); end
    $display("DIV 80000000/ffffffff: hi=%h lo=%h", hi, lo);
    launch(MD_DIVU, 32'd5, 32'd0, 1'b1);
    wait_done(e, b);
    n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL divu0_lo: got %h expected ffffffff", lo); end
    n_checks++; if (hi !== 32'd5) begin n_errors++; $display("FAIL divu0_hi: got %h expected 00000005", hi); end
    $display("DIVU 5/0: hi=%h lo=%h", hi, lo);
    launch(MD_DIV, 32'hFFFF_FFFB, 32'd0, 1'b1);
    wait_done(e, b);
    n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL div0_lo: got %h expected ffffffff", lo); end
    n_checks++; if (hi !== 32'hFFFF_FFFB) begin n_errors++; $display("FAIL div0_hi: got %h expected fffffffb", hi); end
    $display("DIV -5/0: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_mt_and_busy();
    int e, b;
    @(negedge clk);
    mtlo = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    mtlo = 1'b0;
    n_checks++; if (lo !== 32'h0000_1234) begin n_errors++; $display("FAIL mtlo_lo: got %h expected 00001234", lo); end
    n_checks++; if (hi !== 32'hFFFF_FFFB) begin n_errors++; $display("FAIL mtlo_hi_keep: got %h expected fffffffb", hi); end
    $display("MTLO 1234: hi=%h lo=%h", hi, lo);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    n_checks++; if (hi !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL mtboth_hi: got %h expected cafef00d", hi); end
    n_checks++; if (lo !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL mtboth_lo: got %h expected cafef00d", lo); end
    $display("MTHI+MTLO cafef00d: hi=%h lo=%h", hi, lo);
    launch(MD_MULTU, 32'd3, 32'd5, 1'b0);
    repeat (5) @(negedge clk);
    mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    launch(MD_DIVU, 32'd1, 32'd1, 1'b0);
    mthi = 1'b0;
    n_checks++; if (hi !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL busy_mthi_ignored: got %h expected cafef00d", hi); end
    wait_done(e, b);
    n_checks++; if (e !== 27) begin n_errors++; $display("FAIL busy_start_latency: got %0d edges expected 27", e); end
    n_checks++; if (lo !== 32'd15) begin n_errors++; $display("FAIL busy_result_lo: got %h expected 0000000f", lo); end
    n_checks++; if (hi !== 32'd0) begin n_errors++; $display("FAIL busy_result_hi: got %h expected 00000000", hi); end
    $display("MULTU 3*5 with ignored start/mthi: hi=%h lo=%h", hi, lo);
    mthi = 1'b1; wdata = 32'h0000_0077;
    @(negedge clk);
    mthi = 1'b0;
    n_checks++; if (hi !== 32'h0000_0077) begin n_errors++; $display("FAIL done_mthi: got %h expected 00000077", hi); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL no_queue_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL done_pulse_width: got %b expected 0", done); end
    $display("MTHI during DONE: hi=%h lo=%h busy=%b", hi, lo, busy);
  endtask

  task automatic test_reset_mid();
    int e, b;
    launch(MD_MULTU, 32'd9, 32'd9, 1'b1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL midreset_done: got %b expected 0", done); end
    n_checks++; if (hi !== 32'h0) begin n_errors++; $display("FAIL midreset_hi: got %h expected 00000000", hi); end
    n_checks++; if (lo !== 32'h0) begin n_errors++; $display("FAIL midreset_lo: got %h expected 00000000", lo); end
    $display("reset mid-CALC: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    launch(MD_MULTU, 32'd6, 32'd7, 1'b1);
    wait_done(e, b);
    n_checks++; if (e !== 33) begin n_errors++; $display("FAIL post_reset_latency: got %0d edges expected 33", e); end
    n_checks++; if (lo !== 32'd42) begin n_errors++; $display("FAIL post_reset_lo: got %h expected 0000002a", lo); end
    n_checks++; if (hi !== 32'd0) begin n_errors++; $display("FAIL post_reset_hi: got %h expected 00000000", hi); end
    $display("MULTU 6*7 after reset: hi=%h lo=%h", hi, lo);
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_back_to_back();
    test_div_special();
    test_mt_and_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
